mor1kx_bus_arb_wb32: RTL and testbench

- Two-requester arbiter that shares one 32-bit CPU-side bus port (the Wishbone bus bridge's cpu_* port) between the instruction-fetch and load/store units.
- Sits between the fetch/LSU bus ports and the Wishbone bridge.
- Grants whole transactions, including bursts, to one requester at a time.
- Applies either fixed data-side priority or round-robin, with a starvation limit on the instruction side.

---
 rtl/mor1kx_bus_arb_wb32_if.sv | 48 ++++
 rtl/mor1kx_bus_arb_wb32.sv | 114 +++++++++++
 tb/tb_mor1kx_bus_arb_wb32.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mor1kx_bus_arb_wb32_if.sv
// Bus bundle between the fetch/LSU ports, the arbiter and the Wishbone bridge cpu_* port.
// Signal suffixes are from the arbiter's point of view; slave is the arbiter, master the surroundings.
interface mor1kx_bus_arb_wb32_if;
   logic [31:0] ibus_adr_i;
   logic        ibus_req_i;
   logic        ibus_burst_i;
   logic        ibus_ack_o;
   logic        ibus_err_o;
   logic [31:0] ibus_dat_o;

   logic [31:0] dbus_adr_i;
   logic [31:0] dbus_dat_i;
   logic        dbus_req_i;
   logic [3:0]  dbus_bsel_i;
   logic        dbus_we_i;
   logic        dbus_burst_i;
   logic        dbus_ack_o;
   logic        dbus_err_o;
   logic [31:0] dbus_dat_o;

   logic [31:0] cpu_adr_o;
   logic [31:0] cpu_dat_o;
   logic        cpu_req_o;
   logic [3:0]  cpu_bsel_o;
   logic        cpu_we_o;
   logic        cpu_burst_o;
   logic        cpu_ack_i;
   logic        cpu_err_i;
   logic [31:0] cpu_dat_i;

   modport slave (
      input  ibus_adr_i, ibus_req_i, ibus_burst_i,
      output ibus_ack_o, ibus_err_o, ibus_dat_o,
      input  dbus_adr_i, dbus_dat_i, dbus_req_i, dbus_bsel_i, dbus_we_i, dbus_burst_i,
      output dbus_ack_o, dbus_err_o, dbus_dat_o,
      output cpu_adr_o, cpu_dat_o, cpu_req_o, cpu_bsel_o, cpu_we_o, cpu_burst_o,
      input  cpu_ack_i, cpu_err_i, cpu_dat_i
   );

   modport master (
      output ibus_adr_i, ibus_req_i, ibus_burst_i,
      input  ibus_ack_o, ibus_err_o, ibus_dat_o,
      output dbus_adr_i, dbus_dat_i, dbus_req_i, dbus_bsel_i, dbus_we_i, dbus_burst_i,
      input  dbus_ack_o, dbus_err_o, dbus_dat_o,
      input  cpu_adr_o, cpu_dat_o, cpu_req_o, cpu_bsel_o, cpu_we_o, cpu_burst_o,
      output cpu_ack_i, cpu_err_i, cpu_dat_i
   );
endinterface

// File: rtl/mor1kx_bus_arb_wb32.sv
// Arbiter sharing the bridge cpu_* port between instruction fetch and load/store.
// Whole transactions (bursts included) are granted; a turnaround gap separates owners.
module mor1kx_bus_arb_wb32 #(
   parameter string       ARB_MODE     = "DATA_PRIO",
   parameter int unsigned STARVE_LIMIT = 4,
   parameter int unsigned TURNAROUND   = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   mor1kx_bus_arb_wb32_if.slave bus,
   output logic [1:0]           grant_o
);

   typedef enum logic [1:0] {ARB_IDLE, ARB_IBUS, ARB_DBUS, ARB_TURN} arb_state_e;
   typedef enum logic {OWN_IBUS, OWN_DBUS} owner_e;

   localparam bit         RR_MODE    = (ARB_MODE == "ROUND_ROBIN");
   localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
   localparam logic [1:0] TURN_LOAD  = 2'(TURNAROUND - 1);

   arb_state_e state_q, state_d;
   owner_e     last_owner_q, last_owner_d;
   logic [3:0] starve_cnt_q, starve_cnt_d;
   logic [1:0] turn_cnt_q, turn_cnt_d;

   logic is_dbus, own_req, own_burst, starve_hit, pick_ibus;

   assign is_dbus    = (state_q == ARB_DBUS);
   assign own_req    = is_dbus ? bus.dbus_req_i   : bus.ibus_req_i;
   assign own_burst  = is_dbus ? bus.dbus_burst_i : bus.ibus_burst_i;
   assign starve_hit = (STARVE_LIMIT != 0) && (starve_cnt_q == STARVE_MAX);
   // ibus wins when alone, when starved, or when round-robin says it is its turn.
   assign pick_ibus  = bus.ibus_req_i &&
                       (!bus.dbus_req_i || starve_hit || (RR_MODE && last_owner_q == OWN_DBUS));

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ARB_IDLE;
         last_owner_q <= OWN_IBUS;
         starve_cnt_q <= '0;
         turn_cnt_q   <= '0;
      end else begin
         state_q      <= state_d;
         last_owner_q <= last_owner_d;
         starve_cnt_q <= starve_cnt_d;
         turn_cnt_q   <= turn_cnt_d;
      end
   end

   // NOTE: every signal written here gets a default first, so no path can infer a latch.
   always_comb begin
      state_d         = state_q;
      last_owner_d    = last_owner_q;
      starve_cnt_d    = starve_cnt_q;
      turn_cnt_d      = turn_cnt_q;
      grant_o         = 2'b00;
      bus.cpu_adr_o   = '0;
      bus.cpu_dat_o   = '0;
      bus.cpu_req_o   = 1'b0;
      bus.cpu_bsel_o  = '0;
      bus.cpu_we_o    = 1'b0;
      bus.cpu_burst_o = 1'b0;
      bus.ibus_ack_o  = 1'b0;
      bus.ibus_err_o  = 1'b0;
      bus.ibus_dat_o  = '0;
      bus.dbus_ack_o  = 1'b0;
      bus.dbus_err_o  = 1'b0;
      bus.dbus_dat_o  = '0;

      unique case (state_q)
         ARB_IDLE: begin
            if (!bus.ibus_req_i) starve_cnt_d = '0;
            if (bus.ibus_req_i || bus.dbus_req_i) begin
               if (pick_ibus) begin
                  state_d      = ARB_IBUS;
                  starve_cnt_d = '0;
               end else begin
                  state_d = ARB_DBUS;
                  if (bus.ibus_req_i && starve_cnt_q != 4'hf) starve_cnt_d = starve_cnt_q + 4'd1;
               end
            end
         end

         ARB_IBUS, ARB_DBUS: begin
            grant_o         = is_dbus ? 2'b10 : 2'b01;
            bus.cpu_req_o   = own_req;
            bus.cpu_burst_o = own_burst;
            bus.cpu_adr_o   = is_dbus ? bus.dbus_adr_i  : bus.ibus_adr_i;
            bus.cpu_dat_o   = is_dbus ? bus.dbus_dat_i  : 32'h0;
            bus.cpu_bsel_o  = is_dbus ? bus.dbus_bsel_i : 4'hf;
            bus.cpu_we_o    = is_dbus && bus.dbus_we_i;
            bus.ibus_ack_o  = !is_dbus && own_req && bus.cpu_ack_i;
            bus.ibus_err_o  = !is_dbus && own_req && bus.cpu_err_i;
            bus.dbus_ack_o  = is_dbus && own_req && bus.cpu_ack_i;
            bus.dbus_err_o  = is_dbus && own_req && bus.cpu_err_i;
            bus.ibus_dat_o  = bus.cpu_dat_i;
            bus.dbus_dat_o  = bus.cpu_dat_i;
            // Abort, error, or final beat ends ownership; burst beats keep the grant.
            if (!own_req || bus.cpu_err_i || (bus.cpu_ack_i && !own_burst)) begin
               state_d      = ARB_TURN;
               last_owner_d = is_dbus ? OWN_DBUS : OWN_IBUS;
               turn_cnt_d   = TURN_LOAD;
            end
         end

         ARB_TURN: begin
            if (turn_cnt_q == 2'd0) state_d = ARB_IDLE;
            else                    turn_cnt_d = turn_cnt_q - 2'd1;
         end
      endcase
   end

endmodule

// File: tb/tb_mor1kx_bus_arb_wb32.sv
// Bench for mor1kx_bus_arb_wb32: hand-derived vector table, reset sequence and random traffic
// checked against a transaction-level reference model on two differently parameterised instances.
module tb_mor1kx_bus_arb_wb32;

   typedef struct packed {
      logic [31:0] iadr;
      logic        ireq;
      logic        iburst;
      logic [31:0] dadr;
      logic [31:0] ddat;
      logic        dreq;
      logic [3:0]  dbsel;
      logic        dwe;
      logic        dburst;
      logic        ack;
      logic        err;
      logic [31:0] cdat;
   } in_t;

   typedef struct packed {
      logic [1:0]  grant;
      logic        creq;
      logic [31:0] cadr;
      logic [31:0] cdat;
      logic [3:0]  bsel;
      logic        we;
      logic        cburst;
      logic        iack;
      logic        ierr;
      logic [31:0] idat;
      logic        dack;
      logic        derr;
      logic [31:0] ddat;
   } exp_t;

   // owner: 0 none, 1 ibus, 2 dbus; blocked: gap cycles left before arbitration is allowed
   typedef struct {
      int owner;
      int last;
      int starve;
      int blocked;
   } mstate_t;

   typedef struct packed {
      logic       ireq, iburst, dreq, dwe;
      logic [3:0] dbsel;
      logic       dburst, ack, err;
      logic [1:0] grant;
      logic       creq, we;
      logic [3:0] bsel;
      logic       iack, dack, ierr, derr;
   } vec_t;

   localparam bit A_RR = 1'b0;
   localparam int A_SL = 2;
   localparam int A_T  = 1;
   localparam bit B_RR = 1'b1;
   localparam int B_SL = 0;
   localparam int B_T  = 2;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [1:0] grant_a, grant_b;
   in_t        cur;
   exp_t       obs_a, obs_b;
   mstate_t    ms_a, ms_b;
   vec_t       tbl[$];
   int         n_checks = 0;
   int         n_err    = 0;
   int         cyc      = 0;

   always #5 clk = ~clk;

   mor1kx_bus_arb_wb32_if bus_a ();
   mor1kx_bus_arb_wb32_if bus_b ();

   mor1kx_bus_arb_wb32 #(.ARB_MODE("DATA_PRIO"), .STARVE_LIMIT(A_SL), .TURNAROUND(A_T)) dut_a (
      .clk(clk), .rst_n(rst_n), .bus(bus_a), .grant_o(grant_a));
   mor1kx_bus_arb_wb32 #(.ARB_MODE("ROUND_ROBIN"), .STARVE_LIMIT(B_SL), .TURNAROUND(B_T)) dut_b (
      .clk(clk), .rst_n(rst_n), .bus(bus_b), .grant_o(grant_b));

   assign bus_a.ibus_adr_i = cur.iadr;   assign bus_b.ibus_adr_i = cur.iadr;
   assign bus_a.ibus_req_i = cur.ireq;   assign bus_b.ibus_req_i = cur.ireq;
   assign bus_a.ibus_burst_i = cur.iburst; assign bus_b.ibus_burst_i = cur.iburst;
   assign bus_a.dbus_adr_i = cur.dadr;   assign bus_b.dbus_adr_i = cur.dadr;
   assign bus_a.dbus_dat_i = cur.ddat;   assign bus_b.dbus_dat_i = cur.ddat;
   assign bus_a.dbus_req_i = cur.dreq;   assign bus_b.dbus_req_i = cur.dreq;
   assign bus_a.dbus_bsel_i = cur.dbsel; assign bus_b.dbus_bsel_i = cur.dbsel;
   assign bus_a.dbus_we_i = cur.dwe;     assign bus_b.dbus_we_i = cur.dwe;
   assign bus_a.dbus_burst_i = cur.dburst; assign bus_b.dbus_burst_i = cur.dburst;
   assign bus_a.cpu_ack_i = cur.ack;     assign bus_b.cpu_ack_i = cur.ack;
   assign bus_a.cpu_err_i = cur.err;     assign bus_b.cpu_err_i = cur.err;
   assign bus_a.cpu_dat_i = cur.cdat;    assign bus_b.cpu_dat_i = cur.cdat;

   assign obs_a = {grant_a, bus_a.cpu_req_o, bus_a.cpu_adr_o, bus_a.cpu_dat_o, bus_a.cpu_bsel_o,
                   bus_a.cpu_we_o, bus_a.cpu_burst_o, bus_a.ibus_ack_o, bus_a.ibus_err_o,
                   bus_a.ibus_dat_o, bus_a.dbus_ack_o, bus_a.dbus_err_o, bus_a.dbus_dat_o};
   assign obs_b = {grant_b, bus_b.cpu_req_o, bus_b.cpu_adr_o, bus_b.cpu_dat_o, bus_b.cpu_bsel_o,
                   bus_b.cpu_we_o, bus_b.cpu_burst_o, bus_b.ibus_ack_o, bus_b.ibus_err_o,
                   bus_b.ibus_dat_o, bus_b.dbus_ack_o, bus_b.dbus_err_o, bus_b.dbus_dat_o};

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   function automatic mstate_t mreset();
      mstate_t s;
      s.owner = 0; s.last = 1; s.starve = 0; s.blocked = 0;
      return s;
   endfunction

   // Reference model: one bus cycle of the arbitration rules, expressed per transaction owner.
   function automatic void model_eval(input mstate_t s, input in_t x, input bit rr, input int slim,
                                      input int tround, output exp_t e, output mstate_t n);
      bit is_i, req, burst, want_i;
      n = s;
      e = '0;
      if (s.owner == 0) begin
         if (s.blocked > 0) begin
            n.blocked = s.blocked - 1;
         end else if (x.ireq || x.dreq) begin
            if (x.ireq && x.dreq) want_i = (slim != 0 && s.starve == slim) || (rr && s.last == 2);
            else                  want_i = x.ireq;
            n.owner = want_i ? 1 : 2;
            if (want_i)      n.starve = 0;
            else if (x.ireq) n.starve = (s.starve < 15) ? s.starve + 1 : 15;
            else             n.starve = 0;
         end else begin
            n.starve = 0;
         end
      end else begin
         is_i     = (s.owner == 1);
         req      = is_i ? x.ireq : x.dreq;
         burst    = is_i ? x.iburst : x.dburst;
         e.grant  = is_i ? 2'b01 : 2'b10;
         e.creq   = req;
         e.cburst = burst;
         e.cadr   = is_i ? x.iadr : x.dadr;
         e.cdat   = is_i ? 32'h0 : x.ddat;
         e.bsel   = is_i ? 4'hf : x.dbsel;
         e.we     = is_i ? 1'b0 : x.dwe;
         e.iack   = is_i && req && x.ack;
         e.ierr   = is_i && req && x.err;
         e.dack   = !is_i && req && x.ack;
         e.derr   = !is_i && req && x.err;
         e.idat   = x.cdat;
         e.ddat   = x.cdat;
         if (!req || x.err || (x.ack && !burst)) begin
            n.owner   = 0;
            n.last    = s.owner;
            n.blocked = tround;
         end
      end
   endfunction

   // Drive one cycle of inputs, compare both instances against the model at the falling edge.
   task automatic step(input in_t v);
      exp_t    ea, eb;
      mstate_t na, nb;
      cur = v;
      @(negedge clk);
      model_eval(ms_a, v, A_RR, A_SL, A_T, ea, na);
      model_eval(ms_b, v, B_RR, B_SL, B_T, eb, nb);
      check($sformatf("model_a c%0d", cyc), 256'(obs_a), 256'(ea));
      check($sformatf("model_b c%0d", cyc), 256'(obs_b), 256'(eb));
      ms_a = na;
      ms_b = nb;
      cyc++;
   endtask

   task automatic add(input bit ir, ib, dr, dw, input bit [3:0] bs, input bit db, ak, er,
                      input bit [1:0] g, input bit cr, we, input bit [3:0] be,
                      input bit ia, da, ie, de);
      tbl.push_back('{ir, ib, dr, dw, bs, db, ak, er, g, cr, we, be, ia, da, ie, de});
   endtask

   initial begin
      in_t        v;
      logic [75:0] act, exp;
      logic [31:0] exp_adr;

      // Vectors for dut_a (DATA_PRIO, starve limit 2, one turnaround cycle), one row per cycle.
      // single ibus read, bridge acks two cycles after cpu_req_o
      add(1,0,0,0,4'h0,0,0,0, 2'b00,0,0,4'h0, 0,0,0,0);
      add(1,0,0,0,4'h0,0,0,0, 2'b01,1,0,4'hf, 0,0,0,0);
      add(1,0,0,0,4'h0,0,0,0, 2'b01,1,0,4'hf, 0,0,0,0);
      add(1,0,0,0,4'h0,0,1,0, 2'b01,1,0,4'hf, 1,0,0,0);
      add(0,0,0,0,4'h0,0,0,0, 2'b00,0,0,4'h0, 0,0,0,0);
      add(0,0,0,0,4'h0,0,0,0, 2'b00,0,0,4'h0, 0,0,0,0);
      // simultaneous requests: dbus write with bsel 3 first, then ibus
      add(1,0,1,1,4'h3,0,0,0, 2'b00,0,0,4'h0, 0,0,0,0);
      add(1,0,1,1,4'h3,0,0,0, 2'b10,1,1,4'h3, 0,0,0,0);
      add(1,0,1,1,4'h3,0,1,0, 2'b10,1,1,4'h3, 0,1,0,0);
      add(1,0,0,0,4'h0,0,0,0, 2'b00,0,0,4'h0, 0,0,0,0);
      add(1,0,0,0,4'h0,0,0,0, 2'b00,0,0,4'h0, 0,0,0,0);
      add(1,0,0,0,4'h0,0,1,0, 2'b01,1,0,4'hf, 1,0,0,0);
      add(0,0,0,0,4'h0,0,0,0, 2'b00,0,0,4'h0, 0,0,0,0);
      add(0,0,0,0,4'h0,0,0,0, 2'b00,0,0,4'h0, 0,0,0,0);
      // 8-beat ibus burst with dbus pending
      add(1,1,0,0,4'h0,0,0,0, 2'b00,0,0,4'h0, 0,0,0,0);
      add(1,1,1,0,4'hf,0,0,0, 2'b01,1,0,4'hf, 0,0,0,0);
      for (int k = 0; k < 7; k++) add(1,1,1,0,4'hf,0,1,0, 2'b01,1,0,4'hf, 1,0,0,0);
      add(1,0,1,0,4'hf,0,1,0, 2'b01,1,0,4'hf, 1,0,0,0);
      add(0,0,1,0,4'hf,1,0,0, 2'b00,0,0,4'h0, 0,0,0,0);
      add(0,0,1,0,4'hf,1,0,0, 2'b00,0,0,4'h0, 0,0,0,0);
      // dbus burst hits an error on beat 3, pending ibus follows
      add(1,0,1,0,4'hf,1,1,0, 2'b10,1,0,4'hf, 0,1,0,0);
      add(1,0,1,0,4'hf,1,1,0, 2'b10,1,0,4'hf, 0,1,0,0);
      add(1,0,1,0,4'hf,1,0,1, 2'b10,1,0,4'hf, 0,0,0,1);
      add(1,0,0,0,4'h0,0,0,0, 2'b00,0,0,4'h0, 0,0,0,0);
      add(1,0,0,0,4'h0,0,0,0, 2'b00,0,0,4'h0, 0,0,0,0);
      add(1,0,0,0,4'h0,0,1,0, 2'b01,1,0,4'hf, 1,0,0,0);
      add(0,0,0,0,4'h0,0,0,0, 2'b00,0,0,4'h0, 0,0,0,0);
      add(0,0,0,0,4'h0,0,0,0, 2'b00,0,0,4'h0, 0,0,0,0);
      // both request continuously, single beats: D D I D D I
      for (int t = 0; t < 6; t++) begin
         add(1,0,1,0,4'hf,0,1,0, 2'b00,0,0,4'h0, 0,0,0,0);
         if (t % 3 == 2) add(1,0,1,0,4'hf,0,1,0, 2'b01,1,0,4'hf, 1,0,0,0);
         else            add(1,0,1,0,4'hf,0,1,0, 2'b10,1,0,4'hf, 0,1,0,0);
         add(1,0,1,0,4'hf,0,1,0, 2'b00,0,0,4'h0, 0,0,0,0);
      end
      add(0,0,0,0,4'h0,0,0,0, 2'b00,0,0,4'h0, 0,0,0,0);

      // Reset with requests and a bridge response present: everything must read zero.
      v = '0;
      v.ireq = 1'b1; v.dreq = 1'b1; v.ack = 1'b1; v.cdat = 32'hA5A5_5A5A;
      cur   = v;
      rst_n = 1'b0;
      ms_a  = mreset();
      ms_b  = mreset();
      repeat (2) @(posedge clk);
      #1;
      check("reset_a", 256'(obs_a), 256'(0));
      check("reset_b", 256'(obs_b), 256'(0));
      cur   = '0;
      rst_n = 1'b1;

      foreach (tbl[i]) begin
         v        = '0;
         v.iadr   = 32'h0000_0100;
         v.dadr   = 32'h0000_2000;
         v.ddat   = 32'hDEAD_BEEF;
         v.cdat   = 32'hC0DE_0000 + i;
         v.ireq   = tbl[i].ireq;
         v.iburst = tbl[i].iburst;
         v.dreq   = tbl[i].dreq;
         v.dwe    = tbl[i].dwe;
         v.dbsel  = tbl[i].dbsel;
         v.dburst = tbl[i].dburst;
         v.ack    = tbl[i].ack;
         v.err    = tbl[i].err;
         step(v);
         exp_adr = (tbl[i].grant == 2'b01) ? 32'h100 : (tbl[i].grant == 2'b10) ? 32'h2000 : 32'h0;
         act = {grant_a, bus_a.cpu_req_o, bus_a.cpu_we_o, bus_a.cpu_bsel_o, bus_a.ibus_ack_o,
                bus_a.dbus_ack_o, bus_a.ibus_err_o, bus_a.dbus_err_o, bus_a.cpu_adr_o,
                tbl[i].iack ? bus_a.ibus_dat_o : (tbl[i].dack ? bus_a.dbus_dat_o : 32'h0)};
         exp = {tbl[i].grant, tbl[i].creq, tbl[i].we, tbl[i].bsel, tbl[i].iack, tbl[i].dack,
                tbl[i].ierr, tbl[i].derr, exp_adr, (tbl[i].iack || tbl[i].dack) ? v.cdat : 32'h0};
         check($sformatf("vec%0d", i), 256'(act), 256'(exp));
         @(posedge clk);
         #1;
      end

      // Asynchronous reset in the middle of a dbus burst.
      v = '0;
      v.ireq = 1'b1; v.dreq = 1'b1; v.dburst = 1'b1; v.dadr = 32'h0000_3000; v.cdat = 32'h1357_9BDF;
      for (int k = 0; k < 4; k++) begin
         v.ack = (k >= 2);
         step(v);
         @(posedge clk);
         #1;
      end
      rst_n = 1'b0;
      #2;
      check("async_reset_a", 256'(obs_a), 256'(0));
      check("async_reset_b", 256'(obs_b), 256'(0));
      ms_a = mreset();
      ms_b = mreset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      v.ack = 1'b1;
      step(v);
      check("no_ack_after_reset", 256'({bus_a.ibus_ack_o, bus_a.dbus_ack_o, bus_b.ibus_ack_o, bus_b.dbus_ack_o}), 256'(0));
      @(posedge clk);
      #1;
      v.ack = 1'b0;
      step(v);
      check("first_grant_after_reset", 256'({grant_a, grant_b}), 256'(4'b1010));
      @(posedge clk);
      #1;
      v = '0;
      for (int k = 0; k < 4; k++) begin
         step(v);
         @(posedge clk);
         #1;
      end

      // Random traffic on both instances; requesters tend to hold requests across cycles.
      for (int c = 0; c < 4000; c++) begin
         v.ireq   = v.ireq ? ($urandom_range(0, 99) < 90) : ($urandom_range(0, 99) < 35);
         v.dreq   = v.dreq ? ($urandom_range(0, 99) < 90) : ($urandom_range(0, 99) < 35);
         v.iburst = ($urandom_range(0, 99) < 50);
         v.dburst = ($urandom_range(0, 99) < 50);
         v.dwe    = ($urandom_range(0, 99) < 50);
         v.ack    = ($urandom_range(0, 99) < 45);
         v.err    = ($urandom_range(0, 99) < 4);
         v.dbsel  = 4'($urandom);
         v.iadr   = $urandom;
         v.dadr   = $urandom;
         v.ddat   = $urandom;
         v.cdat   = $urandom;
         step(v);
         @(posedge clk);
         #1;
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
